// File: rtl/seq_stream_checker_if.sv
// +---------------------------------------------------------------------------+
// | seq_stream_checker_if                                                     |
// | Stream, control and status signals of the counting-sequence checker.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface seq_stream_checker_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] limit;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH:0]   count;
    logic [WIDTH-1:0] err_data;

    modport master (
        output start, limit, in_valid, in_data,
        input  in_ready, busy, done, error, count, err_data
    );

    modport slave (
        input  start, limit, in_valid, in_data,
        output in_ready, busy, done, error, count, err_data
    );
endinterface

`default_nettype wire

// File: rtl/seq_stream_checker.sv
// +---------------------------------------------------------------------------+
// | seq_stream_checker                                                        |
// | Checks a 0,1,2,... stream against min(limit, BREAK_VAL); reports done,    |
// | beat count or first mismatch. Optional idle watchdog when the macro       |
// | SEQ_STREAM_CHECKER_TIMEOUT_EN is defined.                                 |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module seq_stream_checker #(
    parameter int WIDTH     = 4,
    parameter int BREAK_VAL = 8,
    parameter int TIMEOUT   = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seq_stream_checker_if.slave bus
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;
    localparam logic [1:0] c_S_ERR  = 2'd3;

    localparam logic [WIDTH:0] c_BREAK = (WIDTH+1)'(BREAK_VAL);
    localparam logic [WIDTH:0] c_ONE   = (WIDTH+1)'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH:0]   r_target;
    logic [WIDTH:0]   r_count;
    logic [WIDTH-1:0] r_err_data;
    logic [WIDTH:0]   w_target;
    logic [WIDTH:0]   w_count_inc;
    logic             w_accept;
    logic             w_match;
    logic             w_last;
    logic             w_timeout;

    assign w_target    = ({1'b0, bus.limit} < c_BREAK) ? {1'b0, bus.limit} : c_BREAK;
    assign w_accept    = (r_state == c_S_RUN) && bus.in_valid && !bus.start;
    // The expected beat value always equals the number of beats accepted so far.
    assign w_match     = ({1'b0, bus.in_data} == r_count);
    assign w_count_inc = r_count + c_ONE;
    assign w_last      = (w_count_inc == r_target);

`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
    localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

    logic [c_IDLE_W-1:0] r_idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (bus.start || w_accept || (r_state != c_S_RUN)) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + c_IDLE_W'(1);
        end
    end

    // Fires on the idle cycle that brings the count up to TIMEOUT.
    assign w_timeout = (r_state == c_S_RUN) && !bus.start && !w_accept &&
                       (r_idle == c_IDLE_W'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect without the watchdog; this keeps it referenced.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.start) begin
            w_next = (w_target == '0) ? c_S_DONE : c_S_RUN;
        end else if (r_state == c_S_RUN) begin
            if (w_accept) begin
                if (!w_match) begin
                    w_next = c_S_ERR;
                end else if (w_last) begin
                    w_next = c_S_DONE;
                end
            end else if (w_timeout) begin
                w_next = c_S_ERR;
            end
        end
    end

    always_comb begin
        bus.in_ready = (r_state == c_S_RUN);
        bus.busy     = (r_state == c_S_RUN);
        bus.done     = (r_state == c_S_DONE);
        bus.error    = (r_state == c_S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_target   <= '0;
            r_count    <= '0;
            r_err_data <= '0;
        end else if (bus.start) begin
            r_target   <= w_target;
            r_count    <= '0;
            r_err_data <= '0;
        end else if (w_accept) begin
            if (w_match) begin
                r_count <= w_count_inc;
            end else begin
                r_err_data <= bus.in_data;
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.err_data = r_err_data;

endmodule

`default_nettype wire
